// File: rtl/data_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_if_pkg
// Purpose  : Shared types and widths for the data_if stream and its endpoints.
// Revision : 1.0 - initial release
// ============================================================================
package data_if_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] data_t;

endpackage : data_if_pkg
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_mem
// Purpose  : Unreset register-array storage, clocked write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/data_if_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : data_if_rx_fifo
// Purpose  : FWFT receive FIFO for the data_if stream, with transfer counter
//            and sticky upstream handshake-violation flag.
// Revision : 1.0 - initial release
// ============================================================================
module data_if_rx_fifo
  import data_if_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xfer_cnt,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_FULL_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic             r_pend;
  logic [WIDTH-1:0] r_pend_data;
  logic             r_proto_err;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rd_data;

  // Flow control comes from registered level only, so in_ready has no
  // combinational path from out_ready.
  assign w_full    = (r_level == C_FULL_LVL);
  assign in_ready  = !w_full;
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Storage is unreset; mask the head so out_data reads zero while empty.
  assign out_data  = out_valid ? w_rd_data : '0;
  assign level     = r_level;
  assign xfer_cnt  = r_xfer_cnt;
  assign proto_err = r_proto_err;

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_push && (r_xfer_cnt != '1)) begin
      r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
    end
  end

  // A refused offer must be repeated unchanged on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_pend      <= in_valid && !in_ready;
      r_pend_data <= in_data;
      if (r_pend && (!in_valid || (in_data != r_pend_data))) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule : data_if_rx_fifo
`default_nettype wire

// File: tb/tb_data_if_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_if_rx_fifo
// Purpose  : Scoreboard bench for data_if_rx_fifo with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_if_rx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       level;
  logic [CNT_W-1:0] xfer_cnt;
  logic             proto_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] exp_q [$];

  data_if_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (level != 3'd0 && n < 20) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check({name, "_drained"}, 32'(level), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_level", 32'(level), 32'd0);
    check("rel_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rel_proto_err", 32'(proto_err), 32'd0);

    // Basic
    push(8'hAB);
    check("basic_head", 32'(out_data), 32'hAB);
    check("basic_valid", 32'(out_valid), 32'd1);
    push(8'hCD);
    check("basic_level2", 32'(level), 32'd2);
    drain("basic");
    check("basic_xfer", 32'(xfer_cnt), 32'd2);

    // Full and wrap
    for (int i = 1; i <= 4; i++) push(8'(i));
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h05;
    exp_q.push_back(8'h05);
    step();
    check("full_hold_level", 32'(level), 32'd4);
    check("full_hold_xfer", 32'(xfer_cnt), 32'd6);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("full_pop_level", 32'(level), 32'd3);
    check("full_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("full_accept_level", 32'(level), 32'd4);
    check("full_accept_xfer", 32'(xfer_cnt), 32'd7);
    check("full_no_err", 32'(proto_err), 32'd0);
    drain("full");

    // Simultaneous push and pop
    push(8'h41);
    push(8'h42);
    in_valid  = 1'b1;
    in_data   = 8'h33;
    exp_q.push_back(8'h33);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sim_level", 32'(level), 32'd2);
    check("sim_head", 32'(out_data), 32'h42);
    drain("sim");
    check("sim_xfer", 32'(xfer_cnt), 32'd10);

    // Protocol violation: refused 0x11 changes to 0x22 while held
    for (int i = 0; i < 4; i++) push(8'h61 + 8'(i));
    in_valid = 1'b1;
    in_data  = 8'h11;
    step();
    check("proto_pre", 32'(proto_err), 32'd0);
    in_data = 8'h22;
    exp_q.push_back(8'h22);
    step();
    check("proto_set", 32'(proto_err), 32'd1);
    out_ready = 1'b1;
    begin
      logic acc;
      int n;
      n = 0;
      while ((in_valid || level != 3'd0) && n < 20) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        step();
        if (acc) in_valid = 1'b0;
        n++;
      end
    end
    out_ready = 1'b0;
    check("proto_drained", 32'(level), 32'd0);
    check("proto_sticky", 32'(proto_err), 32'd1);
    check("proto_xfer", 32'(xfer_cnt), 32'd15);

    // Asynchronous reset mid-operation
    push(8'h71);
    push(8'h72);
    push(8'h73);
    check("mid_level3", 32'(level), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_xfer", 32'(xfer_cnt), 32'd0);
    check("arst_proto_err", 32'(proto_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push(8'h5A);
    check("post_rst_head", 32'(out_data), 32'h5A);
    drain("post_rst");
    check("post_rst_xfer", 32'(xfer_cnt), 32'd1);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_data_if_rx_fifo
`default_nettype wire
